// File: rtl/dog_scale_scheduler.sv
// DoG scale-level scheduler: launches the DoG engine once per level of an
// octave, counts its output beats and reports pass, mismatch, timeout or abort.
module dog_scale_scheduler #(
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned HEIGHT     = 128,
  parameter int unsigned MAX_LEVELS = 4,
  parameter int unsigned LVL_W      = 2,
  parameter int unsigned CNT_W      = 15,
  parameter int unsigned TIMEOUT    = 65536
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       num_levels_i,
  input  logic             abort_i,
  output logic             dog_start_o,
  input  logic             dog_valid_i,
  input  logic             dog_done_i,
  output logic [LVL_W-1:0] level_o,
  output logic [CNT_W-1:0] pix_count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       err_code_o
);

  localparam int unsigned NlevW = $clog2(MAX_LEVELS + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT) + 1;

  localparam logic [CNT_W-1:0] PixTarget = CNT_W'(WIDTH * HEIGHT);
  // Counter value one before the limit: the increment taken there reaches TIMEOUT-1.
  localparam logic [TmoW-1:0]  TmoLast   = TmoW'(TIMEOUT - 2);

  localparam logic [1:0] ErrOk       = 2'b00;
  localparam logic [1:0] ErrCount    = 2'b01;
  localparam logic [1:0] ErrTimeout  = 2'b10;
  localparam logic [1:0] ErrAborted  = 2'b11;

  typedef enum logic [2:0] {StIdle, StLaunch, StRun, StCheck, StFinish} state_e;

  state_e           state_q;
  logic [NlevW-1:0] nlev_q;
  logic [NlevW-1:0] nlev_in;
  logic [LVL_W-1:0] level_q;
  logic [CNT_W-1:0] pix_q;
  logic [TmoW-1:0]  tmo_q;
  logic [1:0]       err_q;
  logic             last_level;

  // Clamp the requested level count into 1..MAX_LEVELS.
  always_comb begin
    nlev_in = NlevW'(num_levels_i);
    if (num_levels_i == 3'd0) begin
      nlev_in = NlevW'(1);
    end else if (32'(num_levels_i) > MAX_LEVELS) begin
      nlev_in = NlevW'(MAX_LEVELS);
    end
  end

  assign last_level = (level_q == LVL_W'(nlev_q - NlevW'(1)));

  // Sequencing FSM with its datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      nlev_q  <= '0;
      level_q <= '0;
      pix_q   <= '0;
      tmo_q   <= '0;
      err_q   <= ErrOk;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            nlev_q  <= nlev_in;
            level_q <= '0;
            err_q   <= ErrOk;
            state_q <= StLaunch;
          end
        end
        StLaunch: begin
          if (abort_i) begin
            err_q   <= ErrAborted;
            state_q <= StFinish;
          end else begin
            pix_q   <= '0;
            tmo_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (abort_i) begin
            err_q   <= ErrAborted;
            state_q <= StFinish;
          end else begin
            // A beat coincident with dog_done still counts.
            if (dog_valid_i && !(&pix_q)) begin
              pix_q <= pix_q + CNT_W'(1);
            end
            tmo_q <= tmo_q + TmoW'(1);
            if (dog_done_i) begin
              state_q <= StCheck;
            end else if (tmo_q == TmoLast) begin
              err_q   <= ErrTimeout;
              state_q <= StFinish;
            end
          end
        end
        StCheck: begin
          if (abort_i) begin
            err_q   <= ErrAborted;
            state_q <= StFinish;
          end else if (pix_q != PixTarget) begin
            err_q   <= ErrCount;
            state_q <= StFinish;
          end else if (last_level) begin
            err_q   <= ErrOk;
            state_q <= StFinish;
          end else begin
            level_q <= level_q + LVL_W'(1);
            state_q <= StLaunch;
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    dog_start_o = (state_q == StLaunch);
    done_o      = (state_q == StFinish);
    busy_o      = (state_q == StLaunch) || (state_q == StRun) || (state_q == StCheck);
    level_o     = level_q;
    pix_count_o = pix_q;
    err_code_o  = err_q;
  end

endmodule

// File: tb/tb_dog_scale_scheduler.sv
// Self-checking bench for dog_scale_scheduler with a randomised DoG engine stub.
module tb_dog_scale_scheduler;

  localparam int W    = 16;
  localparam int H    = 8;
  localparam int PIX  = W * H;
  localparam int MAXL = 4;
  localparam int TMO  = 1000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  num_levels_i;
  logic        abort_i;
  logic        dog_start_o;
  logic        dog_valid_i;
  logic        dog_done_i;
  logic [1:0]  level_o;
  logic [14:0] pix_count_o;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  err_code_o;

  int checks = 0;
  int errors = 0;
  int ds_cnt = 0;
  int dn_cnt = 0;

  dog_scale_scheduler #(
    .WIDTH(W), .HEIGHT(H), .MAX_LEVELS(MAXL), .LVL_W(2), .CNT_W(15), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .num_levels_i(num_levels_i),
    .abort_i(abort_i), .dog_start_o(dog_start_o), .dog_valid_i(dog_valid_i),
    .dog_done_i(dog_done_i), .level_o(level_o), .pix_count_o(pix_count_o),
    .busy_o(busy_o), .done_o(done_o), .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulse counters for dog_start and done.
  always @(posedge clk_i) begin
    if (dog_start_o) ds_cnt++;
    if (done_o) dn_cnt++;
  end

  // Reference: which levels run, final error, final count and final level.
  function automatic void model(input int nreq, input int cnt[8], output int lv,
                                output int err, output int pix, output int lvl);
    int nl;
    nl  = (nreq < 1) ? 1 : ((nreq > MAXL) ? MAXL : nreq);
    lv  = nl;
    err = 0;
    pix = PIX;
    lvl = nl - 1;
    for (int i = 0; i < nl; i++) begin
      if (cnt[i] != PIX) begin
        lv  = i + 1;
        err = 1;
        pix = cnt[i];
        lvl = i;
        break;
      end
    end
  endfunction

  task automatic pulse_start(input int nreq);
    @(negedge clk_i);
    start_i      = 1'b1;
    num_levels_i = 3'(nreq);
    @(posedge clk_i);
    #1;
    start_i      = 1'b0;
    num_levels_i = 3'($urandom);
  endtask

  // Negedges until dog_start is seen; -1 if the bound expires.
  task automatic wait_ds(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i);
      if (dog_start_o) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        n = i;
        break;
      end
    end
  endtask

  // Engine stub: `beats` valids with random gaps, then dog_done.
  task automatic emit(input int beats, input bit coincide, input bit noise);
    for (int b = 0; b < beats; b++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk_i);
        dog_valid_i = 1'b0;
        dog_done_i  = 1'b0;
      end
      @(negedge clk_i);
      dog_valid_i = 1'b1;
      dog_done_i  = coincide && (b == beats - 1);
      if (noise) begin
        start_i      = 1'($urandom_range(0, 1));
        num_levels_i = 3'($urandom);
      end
    end
    if (!coincide || beats == 0) begin
      @(negedge clk_i);
      dog_valid_i = 1'b0;
      dog_done_i  = 1'b1;
    end
    @(posedge clk_i);
    #1;
    dog_valid_i = 1'b0;
    dog_done_i  = 1'b0;
    start_i     = 1'b0;
  endtask

  // Drives a whole run and records observed timing and level sequence.
  task automatic drive_run(input int nreq, input int cnt[8], input int nserve,
                           output int g_first, output bit gaps_ok, output bit lvl_ok,
                           output int dwait);
    int g;
    ds_cnt  = 0;
    dn_cnt  = 0;
    g_first = -1;
    gaps_ok = 1'b1;
    lvl_ok  = 1'b1;
    dwait   = -1;
    pulse_start(nreq);
    for (int l = 0; l < nserve; l++) begin
      wait_ds(g);
      if (l == 0) g_first = g;
      else if (g != 2) gaps_ok = 1'b0;
      if (g < 0) return;
      if (level_o != 2'(l)) lvl_ok = 1'b0;
      // Engine noise during LAUNCH must be ignored.
      dog_valid_i = 1'($urandom_range(0, 1));
      dog_done_i  = 1'($urandom_range(0, 1));
      emit(cnt[l], 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_done(10, dwait);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; num_levels_i = 3'd0;
    dog_valid_i = 1'b0; dog_done_i = 1'b0;
    #3;
    checks++;
    if ({dog_start_o, busy_o, done_o, level_o, pix_count_o, err_code_o} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               {dog_start_o, busy_o, done_o, level_o, pix_count_o, err_code_o});
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || dog_start_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b ds=%b exp 0 0", busy_o, dog_start_o);
    end
  endtask

  task automatic test_reference_runs();
    int cnt[8];
    int nreq, lv, err, pix, lvl, g_first, dwait;
    bit gaps_ok, lvl_ok;
    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < 8; i++) cnt[i] = PIX;
      case (r)
        0: nreq = 3;
        1: begin nreq = 3; cnt[1] = PIX - 1; end
        2: nreq = 0;
        3: nreq = 7;
        default: begin
          nreq = $urandom_range(0, 7);
          for (int i = 0; i < 8; i++)
            if ($urandom_range(0, 4) == 0) cnt[i] = ($urandom_range(0, 1) != 0) ? PIX + 1 : PIX - 1;
        end
      endcase
      model(nreq, cnt, lv, err, pix, lvl);
      drive_run(nreq, cnt, lv, g_first, gaps_ok, lvl_ok, dwait);
      checks++;
      if (g_first !== 1) begin
        errors++; $display("FAIL run%0d first_launch_delay got=%0d exp=1", r, g_first);
      end
      checks++;
      if (gaps_ok !== 1'b1 || lvl_ok !== 1'b1) begin
        errors++; $display("FAIL run%0d relaunch_gap/level got=%b%b exp=11", r, gaps_ok, lvl_ok);
      end
      checks++;
      if (dwait !== 2) begin
        errors++; $display("FAIL run%0d done_delay got=%0d exp=2", r, dwait);
      end
      checks++;
      if (int'(err_code_o) !== err) begin
        errors++; $display("FAIL run%0d err_code got=%0d exp=%0d", r, err_code_o, err);
      end
      checks++;
      if (int'(pix_count_o) !== pix) begin
        errors++; $display("FAIL run%0d pix_count got=%0d exp=%0d", r, pix_count_o, pix);
      end
      checks++;
      if (int'(level_o) !== lvl) begin
        errors++; $display("FAIL run%0d level got=%0d exp=%0d", r, level_o, lvl);
      end
      @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
        errors++; $display("FAIL run%0d post_idle got busy=%b done=%b exp 0 0", r, busy_o, done_o);
      end
      repeat (3) @(negedge clk_i);
      checks++;
      if (ds_cnt !== lv || dn_cnt !== 1) begin
        errors++;
        $display("FAIL run%0d pulses got ds=%0d done=%0d exp ds=%0d done=1", r, ds_cnt, dn_cnt, lv);
      end
      checks++;
      if (int'(err_code_o) !== err || int'(pix_count_o) !== pix) begin
        errors++; $display("FAIL run%0d hold got err=%0d pix=%0d", r, err_code_o, pix_count_o);
      end
    end
  endtask

  task automatic test_timeout();
    int g, n;
    ds_cnt = 0; dn_cnt = 0;
    pulse_start(2);
    wait_ds(g);
    wait_done(TMO + 100, n);
    checks++;
    if (n !== TMO) begin
      errors++; $display("FAIL timeout_delay got=%0d exp=%0d", n, TMO);
    end
    checks++;
    if (err_code_o !== 2'b10) begin
      errors++; $display("FAIL timeout_err got=%b exp=10", err_code_o);
    end
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || ds_cnt !== 1 || dn_cnt !== 1) begin
      errors++;
      $display("FAIL timeout_after got busy=%b ds=%0d done=%0d exp 0 1 1", busy_o, ds_cnt, dn_cnt);
    end
  endtask

  task automatic test_abort();
    int g, n;
    ds_cnt = 0; dn_cnt = 0;
    pulse_start(2);
    wait_ds(g);
    repeat (5) begin
      @(negedge clk_i);
      dog_valid_i = 1'b1;
    end
    @(negedge clk_i);
    dog_valid_i = 1'b0;
    abort_i     = 1'b1;
    @(posedge clk_i);
    #1;
    abort_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || err_code_o !== 2'b11) begin
      errors++;
      $display("FAIL abort_finish got done=%b busy=%b err=%b exp 1 0 11", done_o, busy_o, err_code_o);
    end
    checks++;
    if (pix_count_o !== 15'd5) begin
      errors++; $display("FAIL abort_pix got=%0d exp=5", pix_count_o);
    end
    repeat (10) @(negedge clk_i);
    checks++;
    if (ds_cnt !== 1 || dn_cnt !== 1) begin
      errors++; $display("FAIL abort_pulses got ds=%0d done=%0d exp 1 1", ds_cnt, dn_cnt);
    end
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || err_code_o !== 2'b11) begin
      errors++; $display("FAIL abort_idle_ignored got busy=%b done=%b err=%b", busy_o, done_o, err_code_o);
    end
    pulse_start(1);
    wait_ds(g);
    emit(PIX, 1'b1, 1'b0);
    wait_done(10, n);
    checks++;
    if (n !== 2 || err_code_o !== 2'b00 || int'(pix_count_o) !== PIX) begin
      errors++;
      $display("FAIL abort_rerun got wait=%0d err=%b pix=%0d exp 2 00 %0d", n, err_code_o, pix_count_o, PIX);
    end
  endtask

  task automatic test_async_reset();
    int g, n;
    pulse_start(3);
    wait_ds(g);
    repeat (7) begin
      @(negedge clk_i);
      dog_valid_i = 1'b1;
    end
    @(negedge clk_i);
    dog_valid_i = 1'b0;
    checks++;
    if (pix_count_o !== 15'd7 || busy_o !== 1'b1) begin
      errors++; $display("FAIL pre_reset got pix=%0d busy=%b exp 7 1", pix_count_o, busy_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({dog_start_o, busy_o, done_o, level_o, pix_count_o, err_code_o} !== 22'd0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=0",
               {dog_start_o, busy_o, done_o, level_o, pix_count_o, err_code_o});
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    ds_cnt = 0; dn_cnt = 0;
    pulse_start(2);
    for (int l = 0; l < 2; l++) begin
      wait_ds(g);
      emit(PIX, 1'b0, 1'b0);
    end
    wait_done(10, n);
    checks++;
    if (n !== 2 || err_code_o !== 2'b00 || level_o !== 2'd1 || ds_cnt !== 2) begin
      errors++;
      $display("FAIL reset_rerun got wait=%0d err=%b level=%0d ds=%0d exp 2 00 1 2",
               n, err_code_o, level_o, ds_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_reference_runs();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
